w0rm_bus_initiator: RTL and testbench



---
 rtl/w0rm_bus_initiator_if.sv | 58 +++++
 rtl/w0rm_bus_initiator.sv | 159 +++++++++++++++
 tb/tb_w0rm_bus_initiator.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/w0rm_bus_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module      : w0rm_bus_initiator_if
//  Description : Command, W0RM bus request/response and response-port signals
//                of the W0RM bus initiator, bundled with initiator/environment
//                modports.
//  Revision    : 1.0 - initial release
// ============================================================================
interface w0rm_bus_initiator_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) ();
    // Command port
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;
    // Bus request side
    logic                  mem_valid_o;
    logic                  mem_read_o;
    logic                  mem_write_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_data_o;
    // Bus response side
    logic                  mem_valid_i;
    logic [DATA_WIDTH-1:0] mem_data_i;
    // Response port
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_error;
    // Diagnostics
    logic                  stray_o;

    // Initiator view
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data,
        input  mem_valid_i, mem_data_i,
        input  rsp_ready,
        output cmd_ready,
        output mem_valid_o, mem_read_o, mem_write_o, mem_addr_o, mem_data_o,
        output rsp_valid, rsp_data, rsp_error,
        output stray_o
    );

    // Environment view: command source, peripheral fabric and response sink
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_data,
        output mem_valid_i, mem_data_i,
        output rsp_ready,
        input  cmd_ready,
        input  mem_valid_o, mem_read_o, mem_write_o, mem_addr_o, mem_data_o,
        input  rsp_valid, rsp_data, rsp_error,
        input  stray_o
    );
endinterface
`default_nettype wire

// File: rtl/w0rm_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : w0rm_bus_initiator
//  Description : Single-outstanding W0RM bus initiator. Takes one command over
//                a valid/ready port, issues one bus request, waits for the
//                peripheral response (or a timeout) and returns the result on
//                a held valid/ready response port.
//  Revision    : 1.0 - initial release
// ============================================================================
module w0rm_bus_initiator #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16,
    parameter int WRITE_ACK  = 1
) (
    input wire                  mem_clk,
    input wire                  cpu_reset_n,
    w0rm_bus_initiator_if.master bus
);

    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_REQ  = 2'd1;
    localparam logic [1:0] c_S_WAIT = 2'd2;
    localparam logic [1:0] c_S_RESP = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic                  r_cmd_ready;
    logic                  r_cmd_write;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [DATA_WIDTH-1:0] r_cmd_data;
    logic [c_CNT_W-1:0]    r_count;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_error;
    logic                  r_stray;
    logic                  w_timeout;
    logic                  w_accept;
    logic                  w_posted;

    // Output-side wires
    logic                  w_mem_valid;
    logic                  w_mem_read;
    logic                  w_mem_write;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_data;
    logic                  w_rsp_valid;
    logic [DATA_WIDTH-1:0] w_rsp_data;
    logic                  w_rsp_error;

    // cmd_ready is registered so it is 0 during reset and only rises on a clock edge
    assign w_accept = (r_state == c_S_IDLE) && bus.cmd_valid && r_cmd_ready;
    assign w_posted = r_cmd_write && (WRITE_ACK == 0);

    // Timeout fires on the last counted WAIT cycle; compiled out when disabled
    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign w_timeout = 1'b0;
        end else begin : g_timeout
            assign w_timeout = (r_count == c_CNT_W'(TIMEOUT - 1));
        end
    endgenerate

    // State register
    always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a bus response beats a same-cycle timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: if (w_accept) w_next = c_S_REQ;
            c_S_REQ:  w_next = w_posted ? c_S_RESP : c_S_WAIT;
            c_S_WAIT: if (bus.mem_valid_i || w_timeout) w_next = c_S_RESP;
            c_S_RESP: if (bus.rsp_ready) w_next = c_S_IDLE;
            default:  w_next = c_S_IDLE;
        endcase
    end

    // Command capture, wait counter, response registers, stray flag and ready
    always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            r_cmd_ready <= 1'b0;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_data  <= '0;
            r_count     <= '0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
            r_stray     <= 1'b0;
        end else begin
            r_cmd_ready <= (w_next == c_S_IDLE);

            if (w_accept) begin
                r_cmd_write <= bus.cmd_write;
                r_cmd_addr  <= bus.cmd_addr;
                r_cmd_data  <= bus.cmd_data;
            end

            // Counter restarts from 0 on every WAIT entry and saturates
            if (r_state == c_S_WAIT) begin
                if (r_count != {c_CNT_W{1'b1}}) begin
                    r_count <= r_count + c_CNT_W'(1);
                end
            end else begin
                r_count <= '0;
            end

            if (r_state == c_S_REQ && w_posted) begin
                r_rsp_data  <= '0;
                r_rsp_error <= 1'b0;
            end else if (r_state == c_S_WAIT) begin
                if (bus.mem_valid_i) begin
                    r_rsp_data  <= r_cmd_write ? '0 : bus.mem_data_i;
                    r_rsp_error <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_data  <= '0;
                    r_rsp_error <= 1'b1;
                end
            end

            // Any response strobe outside WAIT is recorded and otherwise ignored
            if (bus.mem_valid_i && (r_state != c_S_WAIT)) begin
                r_stray <= 1'b1;
            end
        end
    end

    // Output decode: bus fields are only non-zero during the single REQ cycle
    always_comb begin
        w_mem_valid = (r_state == c_S_REQ);
        w_mem_read  = (r_state == c_S_REQ) && !r_cmd_write;
        w_mem_write = (r_state == c_S_REQ) && r_cmd_write;
        w_mem_addr  = (r_state == c_S_REQ) ? r_cmd_addr : '0;
        w_mem_data  = ((r_state == c_S_REQ) && r_cmd_write) ? r_cmd_data : '0;
        w_rsp_valid = (r_state == c_S_RESP);
        w_rsp_data  = (r_state == c_S_RESP) ? r_rsp_data : '0;
        w_rsp_error = (r_state == c_S_RESP) && r_rsp_error;
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.mem_valid_o = w_mem_valid;
    assign bus.mem_read_o  = w_mem_read;
    assign bus.mem_write_o = w_mem_write;
    assign bus.mem_addr_o  = w_mem_addr;
    assign bus.mem_data_o  = w_mem_data;
    assign bus.rsp_valid   = w_rsp_valid;
    assign bus.rsp_data    = w_rsp_data;
    assign bus.rsp_error   = w_rsp_error;
    assign bus.stray_o     = r_stray;

endmodule
`default_nettype wire

// File: tb/tb_w0rm_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_w0rm_bus_initiator
//  Description : Directed self-checking bench for w0rm_bus_initiator. dut
//                uses TIMEOUT=16/WRITE_ACK=1, dut_p uses posted writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_w0rm_bus_initiator;

    logic mem_clk;
    logic cpu_reset_n;
    int   n_checks;
    int   n_errors;

    w0rm_bus_initiator_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bif ();
    w0rm_bus_initiator_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bifp ();

    w0rm_bus_initiator #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(16), .WRITE_ACK(1)
    ) dut (
        .mem_clk     (mem_clk),
        .cpu_reset_n (cpu_reset_n),
        .bus         (bif)
    );

    w0rm_bus_initiator #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(16), .WRITE_ACK(0)
    ) dut_p (
        .mem_clk     (mem_clk),
        .cpu_reset_n (cpu_reset_n),
        .bus         (bifp)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    // Compare one observed value against its hand-computed expectation
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1ns past the rising edge
    task automatic step();
        @(posedge mem_clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cpu_reset_n = 1'b1;
        bif.cmd_valid = 0;  bif.cmd_write = 0;  bif.cmd_addr = '0;  bif.cmd_data = '0;
        bif.mem_valid_i = 0; bif.mem_data_i = '0; bif.rsp_ready = 0;
        bifp.cmd_valid = 0; bifp.cmd_write = 0; bifp.cmd_addr = '0; bifp.cmd_data = '0;
        bifp.mem_valid_i = 0; bifp.mem_data_i = '0; bifp.rsp_ready = 0;

        // ---------------- Reset state ----------------
        #1 cpu_reset_n = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(bif.cmd_ready), 0);
        chk("rst_mem_valid", 32'(bif.mem_valid_o), 0);
        chk("rst_rsp_valid", 32'(bif.rsp_valid), 0);
        chk("rst_stray", 32'(bif.stray_o), 0);
        #20 cpu_reset_n = 1'b1;   // released at t=22, between edges
        step();
        chk("post_rst_cmd_ready", 32'(bif.cmd_ready), 1);

        // ---------------- Read, 1-cycle responder ----------------
        bif.cmd_valid = 1; bif.cmd_write = 0; bif.cmd_addr = 8'h01; bif.cmd_data = 8'hEE;
        step();                                  // REQ
        bif.cmd_valid = 0;
        chk("rd_req_valid", 32'(bif.mem_valid_o), 1);
        chk("rd_req_read", 32'(bif.mem_read_o), 1);
        chk("rd_req_write", 32'(bif.mem_write_o), 0);
        chk("rd_req_addr", 32'(bif.mem_addr_o), 32'h01);
        chk("rd_req_data", 32'(bif.mem_data_o), 0);
        chk("rd_req_cmd_ready", 32'(bif.cmd_ready), 0);
        step();                                  // WAIT
        chk("rd_wait_pulse_end", 32'(bif.mem_valid_o), 0);
        chk("rd_wait_addr_zero", 32'(bif.mem_addr_o), 0);
        bif.mem_valid_i = 1; bif.mem_data_i = 8'hA5;
        step();                                  // RESP
        bif.mem_valid_i = 0; bif.mem_data_i = '0;
        chk("rd_rsp_valid", 32'(bif.rsp_valid), 1);
        chk("rd_rsp_data", 32'(bif.rsp_data), 32'hA5);
        chk("rd_rsp_error", 32'(bif.rsp_error), 0);
        chk("rd_stray", 32'(bif.stray_o), 0);
        bif.rsp_ready = 1;
        step();                                  // IDLE
        bif.rsp_ready = 0;
        chk("rd_done_rsp_valid", 32'(bif.rsp_valid), 0);
        chk("rd_done_cmd_ready", 32'(bif.cmd_ready), 1);

        // ---------------- Acknowledged write, ack after 4 cycles ----------------
        bif.cmd_valid = 1; bif.cmd_write = 1; bif.cmd_addr = 8'h00; bif.cmd_data = 8'h3C;
        step();                                  // REQ
        bif.cmd_valid = 0;
        chk("wr_req_write", 32'(bif.mem_write_o), 1);
        chk("wr_req_read", 32'(bif.mem_read_o), 0);
        chk("wr_req_data", 32'(bif.mem_data_o), 32'h3C);
        for (int i = 0; i < 4; i++) begin
            step();                              // WAIT cycles 0..3
            chk("wr_wait_cmd_ready", 32'(bif.cmd_ready), 0);
            chk("wr_wait_rsp_valid", 32'(bif.rsp_valid), 0);
            chk("wr_wait_mem_valid", 32'(bif.mem_valid_o), 0);
        end
        bif.mem_valid_i = 1; bif.mem_data_i = 8'h77;
        step();                                  // RESP
        bif.mem_valid_i = 0; bif.mem_data_i = '0;
        chk("wr_rsp_valid", 32'(bif.rsp_valid), 1);
        chk("wr_rsp_data", 32'(bif.rsp_data), 0);
        chk("wr_rsp_error", 32'(bif.rsp_error), 0);
        chk("wr_rsp_cmd_ready", 32'(bif.cmd_ready), 0);
        bif.rsp_ready = 1;
        step();
        bif.rsp_ready = 0;

        // ---------------- Timeout: no response ----------------
        bif.cmd_valid = 1; bif.cmd_write = 0; bif.cmd_addr = 8'h7F;
        step();                                  // REQ
        bif.cmd_valid = 0;
        chk("to_req_addr", 32'(bif.mem_addr_o), 32'h7F);
        for (int i = 1; i <= 16; i++) begin
            step();                              // WAIT count i-1
            chk("to_wait_rsp_valid", 32'(bif.rsp_valid), 0);
        end
        step();                                  // 16 cycles after REQ
        chk("to_rsp_valid", 32'(bif.rsp_valid), 1);
        chk("to_rsp_error", 32'(bif.rsp_error), 1);
        chk("to_rsp_data", 32'(bif.rsp_data), 0);
        bif.rsp_ready = 1;
        step();
        bif.rsp_ready = 0;

        // ---------------- Response on the final WAIT cycle ----------------
        bif.cmd_valid = 1; bif.cmd_write = 0; bif.cmd_addr = 8'h7F;
        step();                                  // REQ
        bif.cmd_valid = 0;
        for (int i = 1; i <= 16; i++) begin
            step();                              // ends in WAIT count 15
        end
        chk("late_wait_rsp_valid", 32'(bif.rsp_valid), 0);
        bif.mem_valid_i = 1; bif.mem_data_i = 8'h5A;
        step();
        bif.mem_valid_i = 0; bif.mem_data_i = '0;
        chk("late_rsp_valid", 32'(bif.rsp_valid), 1);
        chk("late_rsp_error", 32'(bif.rsp_error), 0);
        chk("late_rsp_data", 32'(bif.rsp_data), 32'h5A);
        bif.rsp_ready = 1;
        step();
        bif.rsp_ready = 0;

        // ---------------- Backpressure ----------------
        bif.cmd_valid = 1; bif.cmd_write = 0; bif.cmd_addr = 8'h05;
        step();                                  // REQ
        bif.cmd_valid = 0;
        step();                                  // WAIT
        bif.mem_valid_i = 1; bif.mem_data_i = 8'h42;
        step();                                  // RESP
        bif.mem_valid_i = 0; bif.mem_data_i = '0;
        bif.cmd_valid = 1; bif.cmd_write = 1; bif.cmd_addr = 8'h10; bif.cmd_data = 8'h99;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", 32'(bif.rsp_valid), 1);
            chk("bp_rsp_data", 32'(bif.rsp_data), 32'h42);
            chk("bp_cmd_ready", 32'(bif.cmd_ready), 0);
            chk("bp_mem_valid", 32'(bif.mem_valid_o), 0);
            step();
        end
        bif.rsp_ready = 1;
        step();                                  // IDLE
        bif.rsp_ready = 0;
        chk("bp_rel_rsp_valid", 32'(bif.rsp_valid), 0);
        chk("bp_rel_cmd_ready", 32'(bif.cmd_ready), 1);
        chk("bp_rel_no_req", 32'(bif.mem_valid_o), 0);
        step();                                  // REQ for the held command
        bif.cmd_valid = 0;
        chk("bp_new_req_valid", 32'(bif.mem_valid_o), 1);
        chk("bp_new_req_addr", 32'(bif.mem_addr_o), 32'h10);
        chk("bp_new_req_data", 32'(bif.mem_data_o), 32'h99);
        step();                                  // WAIT
        bif.mem_valid_i = 1; bif.mem_data_i = 8'hFF;
        step();                                  // RESP
        bif.mem_valid_i = 0; bif.mem_data_i = '0;
        chk("bp_new_rsp_data", 32'(bif.rsp_data), 0);
        bif.rsp_ready = 1;
        step();
        bif.rsp_ready = 0;
        chk("main_stray_clear", 32'(bif.stray_o), 0);

        // ---------------- Posted write and stray response ----------------
        bifp.cmd_valid = 1; bifp.cmd_write = 1; bifp.cmd_addr = 8'h20; bifp.cmd_data = 8'h11;
        step();                                  // REQ
        bifp.cmd_valid = 0;
        chk("pw_req_write", 32'(bifp.mem_write_o), 1);
        chk("pw_req_data", 32'(bifp.mem_data_o), 32'h11);
        step();                                  // RESP directly
        chk("pw_rsp_valid", 32'(bifp.rsp_valid), 1);
        chk("pw_rsp_data", 32'(bifp.rsp_data), 0);
        chk("pw_rsp_error", 32'(bifp.rsp_error), 0);
        bifp.rsp_ready = 1;
        step();                                  // IDLE
        bifp.rsp_ready = 0;
        chk("pw_idle_stray", 32'(bifp.stray_o), 0);
        bifp.mem_valid_i = 1; bifp.mem_data_i = 8'hC3;
        step();
        bifp.mem_valid_i = 0; bifp.mem_data_i = '0;
        chk("pw_stray_set", 32'(bifp.stray_o), 1);
        chk("pw_stray_cmd_ready", 32'(bifp.cmd_ready), 1);
        chk("pw_stray_rsp_valid", 32'(bifp.rsp_valid), 0);
        step();
        step();
        chk("pw_stray_sticky", 32'(bifp.stray_o), 1);

        // ---------------- Reset mid-WAIT ----------------
        bif.cmd_valid = 1; bif.cmd_write = 0; bif.cmd_addr = 8'h33;
        step();                                  // REQ
        bif.cmd_valid = 0;
        step();                                  // WAIT
        step();                                  // WAIT
        #2 cpu_reset_n = 1'b0;
        #1;
        chk("mr_cmd_ready", 32'(bif.cmd_ready), 0);
        chk("mr_mem_valid", 32'(bif.mem_valid_o), 0);
        chk("mr_mem_addr", 32'(bif.mem_addr_o), 0);
        chk("mr_rsp_valid", 32'(bif.rsp_valid), 0);
        chk("mr_p_stray", 32'(bifp.stray_o), 0);
        #2 cpu_reset_n = 1'b1;
        step();
        chk("mr_post_cmd_ready", 32'(bif.cmd_ready), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mr_no_rsp", 32'(bif.rsp_valid), 0);
            chk("mr_no_req", 32'(bif.mem_valid_o), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
